// File: rtl/uart_rx.sv
// UART 8N1 receive engine: oversamples a 2-flop synchronized serial line at 16x baud
// and presents each byte with a one-cycle done strobe and a framing-error flag.
module uart_rx #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    input  logic            i_tick,
    output logic [DBIT-1:0] o_data,
    output logic            o_rx_done,
    output logic            o_frame_err
);

    localparam int unsigned SW = 4;
    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sync1;
    logic            r_rx_s;
    logic [SW-1:0]   r_s;
    logic [SW-1:0]   w_s_nxt;
    logic [NW-1:0]   r_n;
    logic [NW-1:0]   w_n_nxt;
    logic [DBIT-1:0] r_b;
    logic [DBIT-1:0] w_b_nxt;
    logic            w_done;
    logic [DBIT-1:0] r_data;
    logic            r_rx_done;
    logic            r_frame_err;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_rx_s  <= r_sync1;
        end
    end

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_b     <= w_b_nxt;
        end
    end

    // Next-state logic: counters only advance on the oversampling tick
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_b_nxt     = r_b;
        w_done      = 1'b0;

        case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = START;
                    w_s_nxt     = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (r_s == SW'(7)) begin
                        if (!r_rx_s) begin
                            w_state_nxt = DATA;
                            w_s_nxt     = '0;
                            w_n_nxt     = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_s_nxt = r_s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (r_s == SW'(15)) begin
                        w_s_nxt = '0;
                        w_b_nxt = {r_rx_s, r_b[DBIT-1:1]};
                        if (r_n == NW'(DBIT - 1)) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_n_nxt = r_n + NW'(1);
                        end
                    end else begin
                        w_s_nxt = r_s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (r_s == SW'(SB_TICK - 1)) begin
                        w_state_nxt = IDLE;
                        w_done      = 1'b1;
                    end else begin
                        w_s_nxt = r_s + SW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output registers: byte and stop-bit status captured on the final stop tick
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data      <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_done <= w_done;
            if (w_done) begin
                r_data      <= r_b;
                r_frame_err <= ~r_rx_s;
            end
        end
    end

    assign o_data      = r_data;
    assign o_rx_done   = r_rx_done;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are built from bytes at the bit level, the expected
// byte/framing result is queued per frame, and a monitor compares on every done strobe.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       tick;
    logic [7:0] data;
    logic       done;
    logic       ferr;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_rx        (rx),
        .i_tick      (tick),
        .o_data      (data),
        .o_rx_done   (done),
        .o_frame_err (ferr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   n_sent   = 0;
    int   n_strobe = 0;
    logic tick_en;
    int   tick_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Tick generator: one clock wide every 4 clocks, can be stalled
    initial begin
        tick     = 1'b0;
        tick_en  = 1'b1;
        tick_cnt = 0;
        forever begin
            @(negedge clk);
            tick     = tick_en && (tick_cnt == 3);
            tick_cnt = (tick_cnt + 1) % 4;
        end
    end

    // Wait for n tick edges, then return at the following negedge
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!tick);
        end
        @(negedge clk);
    endtask

    // Serial frame at 16 ticks/bit; expectation: the byte, and a framing error iff stop is low
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_ticks,
                              input int stall_bit, input int idle_after);
        exp_t e;
        e.d  = b;
        e.fe = (stop_v == 1'b0);
        sb.push_back(e);
        n_sent++;
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == stall_bit) begin
                wait_ticks(5);
                tick_en = 1'b0;
                repeat (100) @(negedge clk);
                tick_en = 1'b1;
                wait_ticks(11);
            end else begin
                wait_ticks(16);
            end
        end
        rx = stop_v;
        wait_ticks(stop_ticks);
        rx = 1'b1;
        wait_ticks(idle_after);
    endtask

    task automatic send_glitch();
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(20);
    endtask

    // Start a frame, then reset in the middle of data bit abort_bit
    task automatic send_abort(input logic [7:0] b, input int abort_bit);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < abort_bit; i++) begin
            rx = b[i];
            wait_ticks(16);
        end
        rx = b[abort_bit];
        wait_ticks(6);
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_data", 32'(data), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_ferr", 32'(ferr), 32'h0);
        wait_ticks(20);
    endtask

    // Monitor: every strobe cycle consumes exactly one expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                n_strobe++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got data 0x%0h ferr %0b expected no strobe at %0t",
                             data, ferr, $time);
                end else begin
                    e = sb.pop_front();
                    check("rx_data", 32'(data), 32'(e.d));
                    check("frame_err", 32'(ferr), 32'(e.fe));
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rb;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_data", 32'(data), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_ferr", 32'(ferr), 32'h0);
        reset = 1'b0;
        wait_ticks(2);

        send_frame(8'hA5, 1'b1, 16, -1, 4);
        send_frame(8'h00, 1'b1, 16, -1, 0);
        send_frame(8'hFF, 1'b1, 16, -1, 6);
        send_glitch();
        send_frame(8'h3C, 1'b1, 16, -1, 4);
        // Short low stop so the line is high again before a break could look like a start
        send_frame(8'h3C, 1'b0, 12, -1, 4);
        send_frame(8'h11, 1'b1, 16, -1, 4);
        send_frame(8'h77, 1'b0, 12, -1, 4);
        send_abort(8'hA5, 4);
        send_frame(8'h5A, 1'b1, 16, -1, 4);
        send_frame(8'hC3, 1'b1, 16, 3, 4);

        for (int k = 0; k < 20; k++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 4) == 0)
                send_frame(rb, 1'b0, 12, -1, 4 + int'($urandom_range(0, 3)));
            else
                send_frame(rb, 1'b1, 16, -1, int'($urandom_range(0, 5)));
        end

        for (int k = 0; k < 2000 && sb.size() != 0; k++) @(negedge clk);
        check("queue_drained", 32'(sb.size()), 32'h0);
        check("strobe_count", 32'(n_strobe), 32'(n_sent));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
